// File: rtl/reg_file_access_arbiter_if.sv
// Direct-access register file port: per-register write strobes plus a full
// read_data snapshot of every register.
interface ifc_reg_file_direct_access #(
    parameter int REGISTER_WIDTH = 32,
    parameter int NUM_REGISTERS  = 16
);
    logic [NUM_REGISTERS-1:0]                     write_req;
    logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] write_data;
    logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] read_data;

    modport master (
        output write_req,
        output write_data,
        input  read_data
    );

    modport slave (
        input  write_req,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/reg_file_access_arbiter.sv
// Round-robin sequencer sharing one direct-access register file among N_REQ requesters.
// Optional REG_FILE_ARB_READBACK_EN: write responses carry a readback and flag bit mismatches.
module reg_file_access_arbiter #(
    parameter int REGISTER_WIDTH = 32,
    parameter int NUM_REGISTERS  = 16,
    parameter int ADDR_WIDTH     = 8,
    parameter int N_REQ          = 2,
    parameter int WRITE_LATENCY  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_REQ-1:0]                     req_valid,
    output logic [N_REQ-1:0]                     req_ready,
    input  logic [N_REQ-1:0]                     req_we,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     req_addr,
    input  logic [N_REQ-1:0][REGISTER_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]                     rsp_valid,
    output logic [REGISTER_WIDTH-1:0]            rsp_rdata,
    output logic                                 rsp_err,
    ifc_reg_file_direct_access.master            reg_file
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int RIW = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;
    localparam int CW  = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, SETTLE, RESP} state_t;

    state_t                    state;
    logic [IDW-1:0]            ptr;
    logic [IDW-1:0]            id_q;
    logic [RIW-1:0]            ridx_q;
    logic [REGISTER_WIDTH-1:0] wdata_q;
    logic [REGISTER_WIDTH-1:0] rdata_q;
    logic                      err_q;
    logic [CW-1:0]             cnt;

    logic                      found;
    logic [IDW-1:0]            gnt;
    logic                      hs;
    logic [ADDR_WIDTH-1:0]     g_addr;
    logic [RIW-1:0]            g_ridx;
    logic                      g_in_range;
    int                        idx;

    // Search starts one past the last winner so persistent requesters rotate.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = IDW'(idx);
            end
        end
    end

    assign hs         = !rst && (state == IDLE) && found;
    assign req_ready  = hs ? (N_REQ'(1) << gnt) : '0;
    assign g_addr     = req_addr[gnt];
    assign g_ridx     = g_addr[RIW-1:0];
    assign g_in_range = 32'(g_addr) < 32'(NUM_REGISTERS);

    assign rsp_valid  = (state == RESP) ? (N_REQ'(1) << id_q) : '0;
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;

    assign reg_file.write_req  = (state == WRITE) ? (NUM_REGISTERS'(1) << ridx_q) : '0;
    assign reg_file.write_data = {NUM_REGISTERS{wdata_q}};

`ifdef REG_FILE_ARB_READBACK_EN
    logic [REGISTER_WIDTH-1:0] rb;
    assign rb = reg_file.read_data[ridx_q];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= IDW'(N_REQ - 1);
            id_q    <= '0;
            ridx_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hs) begin
                        ptr     <= gnt;
                        id_q    <= gnt;
                        ridx_q  <= g_ridx;
                        err_q   <= !g_in_range;
                        rdata_q <= '0;
                        if (req_we[gnt]) begin
                            wdata_q <= req_wdata[gnt];
                            state   <= g_in_range ? WRITE : RESP;
                        end else begin
                            if (g_in_range)
                                rdata_q <= reg_file.read_data[g_ridx];
                            state <= RESP;
                        end
                    end
                end
                WRITE: begin
                    cnt <= CW'(WRITE_LATENCY - 1);
                    if (WRITE_LATENCY == 0) begin
`ifdef REG_FILE_ARB_READBACK_EN
                        rdata_q <= rb;
                        err_q   <= (rb != wdata_q);
`endif
                        state <= RESP;
                    end else begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
`ifdef REG_FILE_ARB_READBACK_EN
                        rdata_q <= rb;
                        err_q   <= (rb != wdata_q);
`endif
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_access_arbiter.sv
// Directed bench for reg_file_access_arbiter with an echoing register file model.
// Expected write responses follow REG_FILE_ARB_READBACK_EN.
module tb_reg_file_access_arbiter;

    logic              clk;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [1:0][7:0]   req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic [15:0][31:0] regs;
    int                n_chk = 0;
    int                n_pass = 0;
    int                wr_cnt = 0;
    int                rsp1_cnt = 0;
    logic [15:0]       wr_last = '0;
    logic [31:0]       wd_last = '0;
    int                order [6];

    ifc_reg_file_direct_access #(.REGISTER_WIDTH(32), .NUM_REGISTERS(16)) rf ();

    reg_file_access_arbiter #(
        .REGISTER_WIDTH(32),
        .NUM_REGISTERS (16),
        .ADDR_WIDTH    (8),
        .N_REQ         (2),
        .WRITE_LATENCY (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .reg_file (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: writes land on the clock edge, reads are immediate.
    always @(posedge clk) begin
        if (rst) begin
            regs    <= '0;
            regs[3] <= 32'hDEADBEEF;
        end else begin
            for (int i = 0; i < 16; i++)
                if (rf.write_req[i]) regs[i] <= rf.write_data[i];
        end
    end
    assign rf.read_data = regs;

    always @(negedge clk) begin
        if (rf.write_req != '0) begin
            wr_cnt  = wr_cnt + 1;
            wr_last = rf.write_req;
            wd_last = rf.write_data[0];
        end
        if (rsp_valid[1]) rsp1_cnt = rsp1_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge; returns 1ns after the handshake edge.
    task automatic request(input int id, input logic we, input logic [7:0] a,
                           input logic [31:0] d, input bit keep);
        int n;
        req_valid[id] = 1'b1;
        req_we[id]    = we;
        req_addr[id]  = a;
        req_wdata[id] = d;
        n = 0;
        #1;
        while (!req_ready[id] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("grant_seen", 64'(n < 20), 64'd1);
        @(posedge clk);
        #1;
        if (!keep) req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(input int id, input int lat, input logic [31:0] rd,
                            input logic er, input string t);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid[id] && n < 20);
        chk({t, "_lat"}, 64'(n), 64'(lat));
        chk({t, "_rdata"}, 64'(rsp_rdata), 64'(rd));
        chk({t, "_err"}, 64'(rsp_err), 64'(er));
        @(negedge clk);
        chk({t, "_pulse_end"}, 64'(rsp_valid), 64'd0);
    endtask

    logic [31:0] exp_wr_rd;

    initial begin
`ifdef REG_FILE_ARB_READBACK_EN
        exp_wr_rd = 32'h12345678;
`else
        exp_wr_rd = 32'h0;
`endif
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_err", 64'(rsp_err), 64'd0);
        chk("rst_write_req", 64'(rf.write_req), 64'd0);
        chk("rst_write_data0", 64'(rf.write_data[0]), 64'd0);
        req_valid = 2'b11;
        req_addr  = {8'd9, 8'd3};
        #1;
        chk("rst_ready_gated", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_grant", 64'(req_ready), 64'b01);
        req_valid[1] = 1'b0;

        // Read addr 3 by requester 0
        request(0, 1'b0, 8'd3, 32'h0, 1'b0);
        wait_rsp(0, 1, 32'hDEADBEEF, 1'b0, "rd3");

        // Write addr 5 by requester 1
        wr_cnt = 0;
        request(1, 1'b1, 8'd5, 32'h12345678, 1'b0);
        wait_rsp(1, 4, exp_wr_rd, 1'b0, "wr5");
        chk("wr5_pulses", 64'(wr_cnt), 64'd1);
        chk("wr5_strobe", 64'(wr_last), 64'h0020);
        chk("wr5_wdata", 64'(wd_last), 64'h12345678);
        request(1, 1'b0, 8'd5, 32'h0, 1'b0);
        wait_rsp(1, 1, 32'h12345678, 1'b0, "rd5");

        // Round robin with both requesters persistent
        req_we    = 2'b00;
        req_addr  = {8'd5, 8'd3};
        req_valid = 2'b11;
        begin
            int k;
            k = 0;
            for (int c = 0; c < 40 && k < 6; c++) begin
                #1;
                if (req_ready != '0) begin
                    order[k] = req_ready[1] ? 1 : 0;
                    k++;
                end
                @(negedge clk);
            end
            req_valid = 2'b00;
            chk("rr_count", 64'(k), 64'd6);
            for (int i = 0; i < 6; i++)
                chk($sformatf("rr_order%0d", i), 64'(order[i]), 64'(i % 2));
        end
        repeat (2) @(negedge clk);

        // Out-of-range write
        wr_cnt = 0;
        request(0, 1'b1, 8'd20, 32'h55, 1'b0);
        wait_rsp(0, 1, 32'h0, 1'b1, "oor");
        chk("oor_no_pulse", 64'(wr_cnt), 64'd0);

        // Reset during SETTLE, requester keeps its request pending
        wr_cnt   = 0;
        rsp1_cnt = 0;
        request(1, 1'b1, 8'd7, 32'hA5A5, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_rsp", 64'(rsp_valid), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_wreq", 64'(rf.write_req), 64'd0);
        rst = 1'b0;
        #1;
        chk("regrant", 64'(req_ready), 64'b10);
        chk("dropped_rsp", 64'(rsp1_cnt), 64'd0);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
`ifdef REG_FILE_ARB_READBACK_EN
        wait_rsp(1, 4, 32'hA5A5, 1'b0, "rewr");
`else
        wait_rsp(1, 4, 32'h0, 1'b0, "rewr");
`endif
        chk("rewr_rsp_count", 64'(rsp1_cnt), 64'd1);
        chk("rewr_pulses", 64'(wr_cnt), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
